// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe: pipelined barrel shifter with valid/ready handshakes.
//
// Shifts or rotates a WIDTH-bit word left or right by 0..WIDTH-1 positions.
// Stage k applies a conditional shift of 2^k, so there are $clog2(WIDTH) stages
// and a beat takes STAGES cycles from acceptance to out_valid. WIDTH must be a
// power of two and at least 4.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   input beat present
//   in_ready   stage 0 can accept a beat this cycle
//   in_data    operand
//   in_shamt   shift amount
//   in_dir     0 = left, 1 = right
//   in_mode    00 logical, 01 rotate, 10 arithmetic, 11 treated as logical
//   out_valid  result beat present
//   out_ready  downstream accepts the result
//   out_data   shifted result
//   out_zero   high when out_data == 0 (registered with the last stage)
module barrel_shifter_pipe #(
    parameter int unsigned WIDTH = 16,
    localparam int unsigned SHW = $clog2(WIDTH),
    localparam int unsigned STAGES = SHW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic             in_dir,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
);

    // Per-stage registers
    logic [STAGES-1:0] valid_q;
    logic [WIDTH-1:0]  data_q  [STAGES];
    logic [SHW-1:0]    shamt_q [STAGES];
    logic [STAGES-1:0] dir_q;
    logic [1:0]        mode_q  [STAGES];
    logic              zero_q;

    // Per-stage inputs (stage 0 from the ports, stage k from stage k-1)
    logic              stage_valid [STAGES];
    logic [WIDTH-1:0]  stage_data  [STAGES];
    logic [SHW-1:0]    stage_shamt [STAGES];
    logic              stage_dir   [STAGES];
    logic [1:0]        stage_mode  [STAGES];
    logic [WIDTH-1:0]  shifted     [STAGES];

    logic [STAGES:0]   ready;

    // Ready chain resolved from the output backwards; an empty stage always
    // accepts, so bubbles collapse even while downstream is stalled.
    always_comb begin
        ready = '0;
        ready[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            ready[k] = !valid_q[k] || ready[k+1];
        end
    end

    always_comb begin
        stage_valid[0] = in_valid;
        stage_data[0]  = in_data;
        stage_shamt[0] = in_shamt;
        stage_dir[0]   = in_dir;
        stage_mode[0]  = in_mode;
        for (int k = 1; k < STAGES; k++) begin
            stage_valid[k] = valid_q[k-1];
            stage_data[k]  = data_q[k-1];
            stage_shamt[k] = shamt_q[k-1];
            stage_dir[k]   = dir_q[k-1];
            stage_mode[k]  = mode_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned S = 1 << k;

        logic [WIDTH-1:0] w;
        logic [WIDTH-1:0] sh;
        logic             is_rot;
        logic             is_arith;

        always_comb begin
            w        = stage_data[k];
            sh       = w;
            is_rot   = (stage_mode[k] == 2'b01);
            // Arithmetic only differs from logical on a right shift
            is_arith = (stage_mode[k] == 2'b10);
            if (stage_shamt[k][k]) begin
                if (!stage_dir[k]) begin
                    if (is_rot) sh = {w[WIDTH-1-S:0], w[WIDTH-1:WIDTH-S]};
                    else        sh = {w[WIDTH-1-S:0], {S{1'b0}}};
                end else begin
                    if (is_rot)        sh = {w[S-1:0], w[WIDTH-1:S]};
                    else if (is_arith) sh = {{S{w[WIDTH-1]}}, w[WIDTH-1:S]};
                    else               sh = {{S{1'b0}}, w[WIDTH-1:S]};
                end
            end
        end

        assign shifted[k] = sh;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dir_q   <= '0;
            zero_q  <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k]  <= '0;
                shamt_q[k] <= '0;
                mode_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ready[k]) begin
                    valid_q[k] <= stage_valid[k];
                    data_q[k]  <= shifted[k];
                    shamt_q[k] <= stage_shamt[k];
                    dir_q[k]   <= stage_dir[k];
                    mode_q[k]  <= stage_mode[k];
                end
            end
            if (ready[STAGES-1]) begin
                zero_q <= (shifted[STAGES-1] == '0);
            end
        end
    end

    assign in_ready  = ready[0];
    assign out_valid = valid_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];
    assign out_zero  = zero_q;

endmodule
